// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32IM decode-stage controller.
// Opcodes, control encodings, funct7/funct3 names and sequencer states.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [2:0] RES_ALU = 3'b000;
  localparam logic [2:0] RES_MEM = 3'b001;
  localparam logic [2:0] RES_PC4 = 3'b010;
  localparam logic [2:0] RES_IMM = 3'b011;
  localparam logic [2:0] RES_MD  = 3'b100;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } md_state_t;

  function automatic logic [3:0] alu_op(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_mext_controller_md_sequencer.sv
// Mul/div issue sequencer: issue, countdown, hold and kill handling.
// RV_MEXT_DIV_EARLY_EN adds div_early_i for early divide completion.
module md_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  input  logic mop_i,
  input  logic div_i,
  input  logic stall_ext_i,
  input  logic flush_i,
`ifdef RV_MEXT_DIV_EARLY_EN
  input  logic div_early_i,
`endif
  output logic start_o,
  output logic kill_o,
  output logic busy_o,
  output logic done_o,
  output logic stall_o
);

  localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_L = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] lat;
  logic             issue, expire;
  logic             start, kill, done, stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    start   = 1'b0;
    kill    = 1'b0;
    done    = 1'b0;
    stall   = 1'b0;
    lat     = div_i ? DIV_L : MUL_L;
    issue   = valid_i & mop_i & (state_q == IDLE) & ~flush_i;
    expire  = (cnt_q == ONE);
`ifdef RV_MEXT_DIV_EARLY_EN
    expire  = expire | (div_q & div_early_i);
`endif
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          start = 1'b1;
          div_d = div_i;
          if (lat == ONE) begin
            done = 1'b1;
            if (stall_ext_i) state_d = HOLD;
          end else begin
            cnt_d   = lat - ONE;
            state_d = BUSY;
            stall   = 1'b1;
          end
        end
      end
      BUSY: begin
        // a redirect outranks a result landing in the same cycle
        if (flush_i) begin
          kill    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (expire) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = stall_ext_i ? HOLD : IDLE;
        end else begin
          cnt_d = cnt_q - ONE;
          stall = 1'b1;
        end
      end
      HOLD: begin
        if (flush_i || !stall_ext_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign start_o = start & rst_n;
  assign kill_o  = kill & rst_n;
  assign done_o  = done & rst_n;
  assign stall_o = stall & rst_n;
  assign busy_o  = (state_q != IDLE) & rst_n;

endmodule

// File: rtl/rv_mext_controller.sv
// RV32IM decode-stage controller with a mul/div issue sequencer.
// Define RV_MEXT_DIV_EARLY_EN to add the DivEarlyDone input.
module rv_mext_controller
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] InstrD,
  input  logic            ValidD,
  input  logic            StallDExt,
  input  logic            FlushD,
`ifdef RV_MEXT_DIV_EARLY_EN
  input  logic            DivEarlyDone,
`endif
  output logic [2:0]      ResultSrcD,
  output logic            RegWriteD,
  output logic            MemWriteD,
  output logic            JumpD,
  output logic            BranchD,
  output logic            ALUSrcD,
  output logic            SrcAsrcD,
  output logic            jumpRegD,
  output logic [2:0]      ImmSrcD,
  output logic [2:0]      funct3D,
  output logic [3:0]      ALUControlD,
  output logic            IllegalD,
  output logic            MdStart,
  output logic [2:0]      MdOpD,
  output logic            MdKill,
  output logic            MdBusy,
  output logic            MdDone,
  output logic            StallDReq
);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       is_mop;
  logic       ill;
  logic       unused_fields;

  assign opc     = InstrD[6:0];
  assign f3      = InstrD[14:12];
  assign f7      = InstrD[31:25];
  assign is_mop  = (opc == OP_R) && (f7 == F7_MEXT);
  assign funct3D = f3;
  assign MdOpD   = f3;
  assign unused_fields = ^{InstrD[24:15], InstrD[11:7]};

  always_comb begin
    ResultSrcD  = RES_ALU;
    RegWriteD   = 1'b0;
    MemWriteD   = 1'b0;
    JumpD       = 1'b0;
    BranchD     = 1'b0;
    ALUSrcD     = 1'b0;
    SrcAsrcD    = 1'b0;
    jumpRegD    = 1'b0;
    ImmSrcD     = IMM_I;
    ALUControlD = ALU_ADD;
    ill         = 1'b0;
    unique case (1'b1)
      opc == OP_R: begin
        RegWriteD = 1'b1;
        if (f7 == F7_MEXT)
          ResultSrcD = RES_MD;
        else if (f7 == F7_BASE ||
                 (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)))
          ALUControlD = alu_op(f3, f7[5]);
        else
          ill = 1'b1;
      end
      opc == OP_I: begin
        RegWriteD   = 1'b1;
        ALUSrcD     = 1'b1;
        ALUControlD = alu_op(f3, (f3 == 3'b101) & f7[5]);
        if (f3 == 3'b001 && f7 != F7_BASE)
          ill = 1'b1;
        if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)
          ill = 1'b1;
      end
      opc == OP_LOAD: begin
        RegWriteD  = 1'b1;
        ALUSrcD    = 1'b1;
        ResultSrcD = RES_MEM;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      opc == OP_STORE: begin
        MemWriteD = 1'b1;
        ALUSrcD   = 1'b1;
        ImmSrcD   = IMM_S;
        ill       = f3[2] || (f3 == 3'b011);
      end
      opc == OP_BR: begin
        BranchD = 1'b1;
        ImmSrcD = IMM_B;
        unique case (f3[2:1])
          2'b00:   ALUControlD = ALU_SUB;
          2'b10:   ALUControlD = ALU_SLT;
          2'b11:   ALUControlD = ALU_SLTU;
          default: ill = 1'b1;
        endcase
      end
      opc == OP_JAL: begin
        JumpD      = 1'b1;
        RegWriteD  = 1'b1;
        ResultSrcD = RES_PC4;
        ImmSrcD    = IMM_J;
      end
      opc == OP_JALR: begin
        JumpD      = 1'b1;
        jumpRegD   = 1'b1;
        RegWriteD  = 1'b1;
        ALUSrcD    = 1'b1;
        ResultSrcD = RES_PC4;
        ill        = (f3 != 3'b000);
      end
      opc == OP_LUI: begin
        RegWriteD  = 1'b1;
        ResultSrcD = RES_IMM;
        ImmSrcD    = IMM_U;
      end
      opc == OP_AUIPC: begin
        RegWriteD = 1'b1;
        ALUSrcD   = 1'b1;
        SrcAsrcD  = 1'b1;
        ImmSrcD   = IMM_U;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      RegWriteD = 1'b0;
      MemWriteD = 1'b0;
      JumpD     = 1'b0;
      BranchD   = 1'b0;
      jumpRegD  = 1'b0;
    end
  end

  assign IllegalD = ill;

  md_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (ValidD),
    .mop_i       (is_mop),
    .div_i       (f3[2]),
    .stall_ext_i (StallDExt),
    .flush_i     (FlushD),
`ifdef RV_MEXT_DIV_EARLY_EN
    .div_early_i (DivEarlyDone),
`endif
    .start_o     (MdStart),
    .kill_o      (MdKill),
    .busy_o      (MdBusy),
    .done_o      (MdDone),
    .stall_o     (StallDReq)
  );

endmodule
